demux1x2_buf: RTL and testbench

- Buffered 1-to-2 demultiplexer for the 16-bit datapath; the inverse of the 2-to-1 operand/result select.
- Steers one 16-bit valid/ready source stream to one of two destination channels, chosen per beat by a select bit.
- Each channel has its own small FIFO, so a stalled destination does not block beats bound for the other destination.
- Sits between the write-back/result source and two consumers, for example the register-file write port and the memory store path.

---
 rtl/demux1x2_buf_pkg.sv | 22 ++
 rtl/demux1x2_buf_sync_fifo.sv | 82 ++++++++
 rtl/demux1x2_buf.sv | 79 +++++++
 tb/tb_demux1x2_buf.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux1x2_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux1x2_buf_pkg
//  Brief    : Shared constants and helpers for the buffered 1-to-2 demux.
//  Revision : 1.0 - initial release
// ============================================================================
package demux1x2_buf_pkg;

    // Datapath width shared by the source and both destination channels.
    localparam int DATA_W = 16;

    // Channel index values carried on the select input.
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Occupancy counters must hold 0..DEPTH inclusive, hence one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux1x2_buf_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : demux1x2_buf_sync_fifo
//  Brief    : Single-clock FIFO with occupancy count and registered flags.
//             The output holds the last popped value while empty.
//  Revision : 1.0 - initial release
// ============================================================================
module demux1x2_buf_sync_fifo
    import demux1x2_buf_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int              PW         = $clog2(DEPTH);
    localparam logic [CW-1:0]   C_FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic [WIDTH-1:0] last_q;

    // Occupancy next state: push and pop together leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, wrapping pointers, count and flags; reset drops every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == C_FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    // While empty the head slot is stale, so present the last popped beat.
    assign dout_o  = empty_q ? last_q : mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule
`default_nettype wire

// File: rtl/demux1x2_buf.sv
`default_nettype none
// ============================================================================
//  Module   : demux1x2_buf
//  Brief    : Buffered 1-to-2 demultiplexer. Each beat is steered by in_sel
//             into a per-channel FIFO so one stalled consumer does not block
//             traffic bound for the other.
//  Revision : 1.0 - initial release
// ============================================================================
module demux1x2_buf
    import demux1x2_buf_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CW-1:0]    cnt0,
    output logic [CW-1:0]    cnt1
);

    logic [1:0]       w_sel_hot;
    logic [1:0]       w_out_ready;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_full;
    logic [1:0]       w_empty;
    logic [WIDTH-1:0] w_dout  [2];
    logic [CW-1:0]    w_count [2];

    assign w_sel_hot   = {in_sel == CH1, in_sel == CH0};
    assign w_out_ready = {out1_ready, out0_ready};

    // Ready looks only at the selected channel's registered full flag, so a
    // consumer's ready never reaches back to the source combinationally.
    assign in_ready = ~w_full[in_sel];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            assign w_push[gi] = in_valid & in_ready & w_sel_hot[gi];
            assign w_pop[gi]  = ~w_empty[gi] & w_out_ready[gi];

            demux1x2_buf_sync_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .CW    (CW)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .push_i  (w_push[gi]),
                .din_i   (in_data),
                .pop_i   (w_pop[gi]),
                .dout_o  (w_dout[gi]),
                .count_o (w_count[gi]),
                .full_o  (w_full[gi]),
                .empty_o (w_empty[gi])
            );
        end
    endgenerate

    assign out0_valid = ~w_empty[0];
    assign out0_data  = w_dout[0];
    assign cnt0       = w_count[0];
    assign out1_valid = ~w_empty[1];
    assign out1_data  = w_dout[1];
    assign cnt1       = w_count[1];

endmodule
`default_nettype wire

// File: tb/tb_demux1x2_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux1x2_buf
//  Brief    : Self-checking bench for demux1x2_buf against a queue-based
//             reference model, with directed and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux1x2_buf;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CW-1:0]    cnt0;
    logic [CW-1:0]    cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one queue per channel plus the last beat each emitted.
    logic [WIDTH-1:0] q0 [$];
    logic [WIDTH-1:0] q1 [$];
    logic [WIDTH-1:0] last0;
    logic [WIDTH-1:0] last1;
    logic [WIDTH-1:0] seen1 [$];

    demux1x2_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    // One clock: compare DUT against the model, then advance the model.
    task automatic step(output logic acc);
        logic exp_rdy;
        logic p0;
        logic p1;
        #1;
        exp_rdy = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        check_val("in_ready",   in_ready,   exp_rdy);
        check_val("out0_valid", out0_valid, q0.size() != 0);
        check_val("out0_data",  out0_data,  (q0.size() != 0) ? q0[0] : last0);
        check_val("cnt0",       cnt0,       q0.size());
        check_val("out1_valid", out1_valid, q1.size() != 0);
        check_val("out1_data",  out1_data,  (q1.size() != 0) ? q1[0] : last1);
        check_val("cnt1",       cnt1,       q1.size());
        acc = in_valid & exp_rdy;
        p0  = out0_ready & (q0.size() != 0);
        p1  = out1_ready & (q1.size() != 0);
        if (p1) seen1.push_back(out1_data);
        @(posedge clk);
        #1;
        if (p0) last0 = q0.pop_front();
        if (p1) last1 = q1.pop_front();
        if (acc) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
    endtask

    initial begin
        logic acc;
        logic stalled;
        int   idx;
        int   budget;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out0_valid", out0_valid, 1'b0);
        check_val("rst_out1_valid", out1_valid, 1'b0);
        check_val("rst_cnt0", cnt0, 0);
        check_val("rst_cnt1", cnt1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Steering with both consumers ready.
        drive(1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b1);
        step(acc);
        drive(1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b1);
        #1;
        check_val("steer_out0_data", out0_data, 16'hA5A5);
        check_val("steer_out0_valid", out0_valid, 1'b1);
        step(acc);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        #1;
        check_val("steer_out1_data", out1_data, 16'h5A5A);
        step(acc);
        step(acc);

        // Fill channel 0 while its consumer stalls.
        drive(1'b1, 1'b0, 16'h1111, 1'b0, 1'b1);
        step(acc);
        drive(1'b1, 1'b0, 16'h2222, 1'b0, 1'b1);
        step(acc);
        drive(1'b1, 1'b0, 16'h3333, 1'b0, 1'b1);
        #1;
        check_val("full_cnt0", cnt0, 2);
        check_val("full_in_ready", in_ready, 1'b0);
        step(acc);
        // Other channel still accepts.
        drive(1'b1, 1'b1, 16'h4444, 1'b0, 1'b1);
        #1;
        check_val("other_in_ready", in_ready, 1'b1);
        step(acc);
        // Full with simultaneous pop: no ready-through.
        drive(1'b1, 1'b0, 16'h5555, 1'b1, 1'b1);
        #1;
        check_val("full_pop_in_ready", in_ready, 1'b0);
        step(acc);
        drive(1'b1, 1'b0, 16'h5555, 1'b0, 1'b1);
        step(acc);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        #1;
        check_val("refill_cnt0", cnt0, 2);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        repeat (3) step(acc);

        // Simultaneous push and pop at count 1.
        drive(1'b1, 1'b0, 16'h7777, 1'b0, 1'b1);
        step(acc);
        drive(1'b1, 1'b0, 16'h8888, 1'b1, 1'b1);
        step(acc);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        #1;
        check_val("pushpop_cnt0", cnt0, 1);
        check_val("pushpop_head", out0_data, 16'h8888);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        repeat (2) step(acc);

        // Ordered stream through channel 1 with a randomly stalling consumer.
        seen1.delete();
        idx    = 0;
        budget = 400;
        while (idx < 16 && budget > 0) begin
            drive(1'b1, 1'b1, WIDTH'(idx), 1'b1, 1'($urandom_range(0, 1)));
            step(acc);
            if (acc) idx++;
            budget--;
        end
        check_val("order_timeout", idx, 16);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        repeat (3) step(acc);
        check_val("order_len", seen1.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("order_%0d", i),
                      (i < seen1.size()) ? 32'(seen1[i]) : 32'hDEAD, i);
        end

        // Randomized traffic obeying the hold-while-stalled rule.
        stalled = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!stalled) begin
                in_valid = 1'($urandom_range(0, 1));
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = WIDTH'($urandom);
            end
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            step(acc);
            stalled = in_valid & ~acc;
        end

        // Reset mid-stream with two beats buffered.
        drive(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        step(acc);
        drive(1'b1, 1'b1, 16'hCAFE, 1'b0, 1'b0);
        step(acc);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("mrst_out0_valid", out0_valid, 1'b0);
        check_val("mrst_out1_valid", out1_valid, 1'b0);
        check_val("mrst_cnt0", cnt0, 0);
        check_val("mrst_cnt1", cnt1, 0);
        check_val("mrst_out0_data", out0_data, 16'h0000);
        check_val("mrst_out1_data", out1_data, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(acc);
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        step(acc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
